// File: rtl/pipe_defs_pkg.sv
// ---------------------------------------------------------------------------
// pipe_defs
//   Shared definitions for the ID->EX pipeline register and its hazard
//   detector:
//     CTRL_W  - width of the decoded control word
//     LD_BIT  - index of MEM_READ (load) inside the control word
//     WB_BIT  - index of REG_WRITE inside the control word
//     REG0    - architectural $zero specifier (never a real dependence)
//     upd_e   - per-edge update decision of the ID->EX register
//     upd_is_bubble() - true for the decisions that insert a bubble
// ---------------------------------------------------------------------------
package pipe_defs;

  localparam int CTRL_W = 12;
  localparam int LD_BIT = 3;
  localparam int WB_BIT = 0;

  localparam logic [4:0] REG0 = 5'd0;

  // What the ID->EX register does on the next rising edge, highest
  // priority first.
  typedef enum logic [2:0] {
    UPD_HOLD    = 3'd0,  // downstream stalled: keep everything
    UPD_FLUSH   = 3'd1,  // taken branch/jump: kill the ID instruction
    UPD_HAZARD  = 3'd2,  // load-use: bubble, ID re-presents next cycle
    UPD_IDLE    = 3'd3,  // ID holds no instruction: bubble
    UPD_CAPTURE = 3'd4   // move the ID instruction into EX
  } upd_e;

  function automatic logic upd_is_bubble(input upd_e upd);
    return (upd == UPD_FLUSH) || (upd == UPD_HAZARD) || (upd == UPD_IDLE);
  endfunction

endpackage : pipe_defs

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard equation. Raised when the
//   instruction in EX is a load whose destination (rt) is a source of the
//   real instruction currently in ID. $zero is never a dependence.
//   The result is suppressed while ex_stall is high because the front end
//   is already frozen by that stall.
//
// Ports
//   ex_valid  in   EX stage holds a real instruction
//   ex_ld     in   MEM_READ bit of the EX control word
//   ex_rt     in   rt specifier of the EX instruction (load destination)
//   id_valid  in   ID stage holds a real instruction
//   id_rs     in   rs specifier of the ID instruction
//   id_rt     in   rt specifier of the ID instruction
//   ex_stall  in   downstream stall (suppresses the hazard output)
//   hz_stall  out  freeze PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module load_use_detect
  import pipe_defs::*;
(
  input  logic       ex_valid,
  input  logic       ex_ld,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_stall,
  output logic       hz_stall
);

  logic rt_nonzero;
  logic src_match;
  logic raw_hazard;

  always_comb begin
    rt_nonzero = (ex_rt != REG0);
    src_match  = (ex_rt == id_rs) || (ex_rt == id_rt);
    raw_hazard = ex_valid & ex_ld & id_valid & rt_nonzero & src_match;
    hz_stall   = raw_hazard & ~ex_stall;
  end

endmodule : load_use_detect

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID->EX pipeline register of the 6-stage MIPS core. Latches PC+4, rs/rt
//   read data, the sign-extended immediate (unmodified), the register
//   specifiers and the decoded control word into EX. Hosts the load-use
//   hazard detector that freezes IF/ID and injects one bubble into EX.
//
// Parameters
//   CTRL_W  width of the control word
//   LD_BIT  MEM_READ bit index in the control word
//   WB_BIT  REG_WRITE bit index in the control word
//
// Ports
//   clk, rst_n                        clock (rising edge), async active-low reset
//   id_valid                          ID holds a real instruction
//   id_pc4/id_rs_data/id_rt_data/id_imm_ext  32-bit ID fields
//   id_rs/id_rt/id_rd                 5-bit register specifiers
//   id_ctrl                           decoded control word
//   ex_stall                          downstream cannot accept: hold EX
//   flush                             taken branch/jump: kill ID->EX move
//   hz_stall                          load-use hazard (combinational)
//   ex_valid                          EX holds a real instruction
//   ex_pc4/ex_rs_data/ex_rt_data/ex_imm      registered 32-bit fields
//   ex_rs/ex_rt/ex_rd                 registered specifiers
//   ex_ctrl                           registered control, zero in a bubble
//   bubble_cnt, stall_cnt             only with ID_EX_PERF_CNT_EN defined:
//                                     bubbles inserted / ex_stall edges,
//                                     both wrapping 32-bit counters
//
// Flow control
//   The EX slot is "valid" when ex_valid=1. ex_stall is the only
//   back-pressure: while it is high nothing in EX changes and flush is
//   ignored (the branch unit must reassert it). Otherwise the slot either
//   takes the ID instruction (id_valid=1, no flush, no hazard) or becomes a
//   bubble. A bubble always carries ex_ctrl=0 and zeroed data so nothing
//   downstream can write a register or start a load from it.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int CTRL_W = pipe_defs::CTRL_W,
  parameter int LD_BIT = pipe_defs::LD_BIT,
  parameter int WB_BIT = pipe_defs::WB_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              hz_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  import pipe_defs::*;

  // Control bit indices must land inside the control word.
  if ((LD_BIT >= CTRL_W) || (WB_BIT >= CTRL_W) || (LD_BIT == WB_BIT)) begin : g_bad_idx
    $error("id_ex_pipe_reg: control bit index out of range or overlapping");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              ex_valid_q,   ex_valid_d;
  logic [31:0]       ex_pc4_q,     ex_pc4_d;
  logic [31:0]       ex_rs_data_q, ex_rs_data_d;
  logic [31:0]       ex_rt_data_q, ex_rt_data_d;
  logic [31:0]       ex_imm_q,     ex_imm_d;
  logic [4:0]        ex_rs_q,      ex_rs_d;
  logic [4:0]        ex_rt_q,      ex_rt_d;
  logic [4:0]        ex_rd_q,      ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;

  upd_e upd;

  // -------------------------------------------------------------------------
  // Load-use hazard: uses only registered EX state and the ID inputs, so
  // there is no combinational path from the downstream stall into the
  // register's own next-state except through the suppression term.
  // -------------------------------------------------------------------------
  load_use_detect u_load_use_detect (
    .ex_valid (ex_valid_q),
    .ex_ld    (ex_ctrl_q[LD_BIT]),
    .ex_rt    (ex_rt_q),
    .id_valid (id_valid),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .ex_stall (ex_stall),
    .hz_stall (hz_stall)
  );

  // -------------------------------------------------------------------------
  // Update decision, highest priority first.
  // -------------------------------------------------------------------------
  always_comb begin
    if (ex_stall) begin
      upd = UPD_HOLD;
    end else if (flush) begin
      upd = UPD_FLUSH;
    end else if (hz_stall) begin
      upd = UPD_HAZARD;
    end else if (!id_valid) begin
      upd = UPD_IDLE;
    end else begin
      upd = UPD_CAPTURE;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state for the EX fields.
  // -------------------------------------------------------------------------
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc4_d     = ex_pc4_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_ctrl_d    = ex_ctrl_q;

    case (upd)
      UPD_HOLD: begin
        // keep everything
      end
      UPD_CAPTURE: begin
        ex_valid_d   = 1'b1;
        ex_pc4_d     = id_pc4;
        ex_rs_data_d = id_rs_data;
        ex_rt_data_d = id_rt_data;
        ex_imm_d     = id_imm_ext;
        ex_rs_d      = id_rs;
        ex_rt_d      = id_rt;
        ex_rd_d      = id_rd;
        ex_ctrl_d    = id_ctrl;
      end
      default: begin
        // Bubble. Data fields are zeroed as well so a bubble is fully
        // deterministic and cannot alias a real load in the detector.
        ex_valid_d   = 1'b0;
        ex_pc4_d     = '0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        ex_ctrl_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_ctrl_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_ctrl_q    <= ex_ctrl_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc4     = ex_pc4_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_ctrl    = ex_ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters: bubbles inserted and downstream stall edges.
  // Both wrap naturally at 32 bits.
  // -------------------------------------------------------------------------
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (upd_is_bubble(upd)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (upd == UPD_HOLD) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule : id_ex_pipe_reg

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//   Directed self-checking bench for id_ex_pipe_reg. Inputs change 1 ns
//   after a rising edge; outputs are sampled there too, away from the edge.
//   With ID_EX_PERF_CNT_EN defined the counter ports are connected and
//   exercised as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_pipe_reg;

  localparam int CW = 12;
  localparam logic [CW-1:0] C_ALU = 12'h001;  // REG_WRITE only
  localparam logic [CW-1:0] C_LW  = 12'h009;  // MEM_READ (bit 3) + REG_WRITE

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          id_valid;
  logic [31:0]   id_pc4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [CW-1:0] id_ctrl;
  logic          ex_stall, flush;
  logic          hz_stall, ex_valid;
  logic [31:0]   ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]   bubble_cnt, stall_cnt;
`endif

  id_ex_pipe_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_pc4     (id_pc4),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm_ext (id_imm_ext),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_ctrl    (id_ctrl),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .hz_stall   (hz_stall),
    .ex_valid   (ex_valid),
    .ex_pc4     (ex_pc4),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm     (ex_imm),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_ctrl    (ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc4, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [CW-1:0] ctrl);
    id_valid   = v;
    id_pc4     = pc4;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_imm_ext = imm;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_ctrl    = ctrl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    ex_stall = 1'b0;
    flush    = 1'b0;
    drive_id(1'b1, 32'h0000_1004, 32'h1111_1111, 32'h2222_2222, 32'h0000_0044,
             5'd1, 5'd2, 5'd3, C_ALU);

    // 1: reset holds everything at zero despite valid ID input
    step();
    step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_pc4",   ex_pc4, 32'd0);
    check("rst_imm",   ex_imm, 32'd0);
    check("rst_rd",    {27'd0, ex_rd}, 32'd0);
    check("rst_ctrl",  {20'd0, ex_ctrl}, 32'd0);
    check("rst_hz",    {31'd0, hz_stall}, 32'd0);
    rst_n = 1'b1;

    // 2: pass-through, immediate not re-extended
    drive_id(1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hFFFF_8000,
             5'd4, 5'd5, 5'd9, C_ALU);
    step();
    check("pt_valid", {31'd0, ex_valid}, 32'd1);
    check("pt_imm",   ex_imm, 32'hFFFF_8000);
    check("pt_rd",    {27'd0, ex_rd}, 32'd9);
    check("pt_pc4",   ex_pc4, 32'h0000_2008);
    check("pt_rsd",   ex_rs_data, 32'hDEAD_BEEF);
    check("pt_rtd",   ex_rt_data, 32'h0BAD_F00D);
    check("pt_rs",    {27'd0, ex_rs}, 32'd4);
    check("pt_rt",    {27'd0, ex_rt}, 32'd5);
    check("pt_ctrl",  {20'd0, ex_ctrl}, {20'd0, C_ALU});

    // 3: load-use on rs: lw rt=8 in EX, add rs=8 in ID
    drive_id(1'b1, 32'h100, 32'h0, 32'h0, 32'h10, 5'd2, 5'd8, 5'd0, C_LW);
    step();
    drive_id(1'b1, 32'h104, 32'h7, 32'h3, 32'h0, 5'd8, 5'd3, 5'd10, C_ALU);
    #1;
    check("lu_hz",        {31'd0, hz_stall}, 32'd1);
    step();
    check("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bub_ctrl",  {20'd0, ex_ctrl}, 32'd0);
    check("lu_bub_rd",    {27'd0, ex_rd}, 32'd0);
    check("lu_hz_clr",    {31'd0, hz_stall}, 32'd0);
    step();
    check("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_cap_rd",    {27'd0, ex_rd}, 32'd10);
    check("lu_cap_ctrl",  {20'd0, ex_ctrl}, {20'd0, C_ALU});
    check("lu_cap_hz",    {31'd0, hz_stall}, 32'd0);

    // load-use on rt, then back-to-back dependent loads
    drive_id(1'b1, 32'h200, 32'h0, 32'h0, 32'h4, 5'd2, 5'd8, 5'd0, C_LW);
    step();
    drive_id(1'b1, 32'h204, 32'h0, 32'h0, 32'h8, 5'd8, 5'd9, 5'd0, C_LW);
    #1;
    check("b2b_hz1", {31'd0, hz_stall}, 32'd1);
    step();
    check("b2b_bub1", {31'd0, ex_valid}, 32'd0);
    step();
    check("b2b_cap_rt", {27'd0, ex_rt}, 32'd9);
    drive_id(1'b1, 32'h208, 32'h0, 32'h0, 32'h0, 5'd1, 5'd9, 5'd11, C_ALU);
    #1;
    check("b2b_hz2_rt", {31'd0, hz_stall}, 32'd1);
    step();
    check("b2b_bub2", {31'd0, ex_valid}, 32'd0);
    step();
    check("b2b_cap2_rd", {27'd0, ex_rd}, 32'd11);

    // 4: no false hazards
    drive_id(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, C_LW);
    step();
    drive_id(1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd12, C_ALU);
    #1;
    check("nf_zero_rt", {31'd0, hz_stall}, 32'd0);
    drive_id(1'b1, 32'h308, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd8, C_ALU);
    step();
    drive_id(1'b1, 32'h30C, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd13, C_ALU);
    #1;
    check("nf_nonload", {31'd0, hz_stall}, 32'd0);
    drive_id(1'b1, 32'h310, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, C_LW);
    step();
    drive_id(1'b0, 32'h314, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd14, C_ALU);
    #1;
    check("nf_id_invalid", {31'd0, hz_stall}, 32'd0);

    // hazard suppressed by ex_stall, then flush outranks the hazard
    id_valid = 1'b1;
    ex_stall = 1'b1;
    #1;
    check("sup_hz", {31'd0, hz_stall}, 32'd0);
    ex_stall = 1'b0;
    #1;
    check("sup_hz_off", {31'd0, hz_stall}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_over_hz_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_over_hz_ctrl",  {20'd0, ex_ctrl}, 32'd0);

    // 5: ex_stall beats flush, then flush alone bubbles
    drive_id(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd15, C_ALU);
    step();
    drive_id(1'b1, 32'h404, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd16, C_ALU);
    ex_stall = 1'b1;
    flush    = 1'b1;
    step();
    check("pri_hold_rd",    {27'd0, ex_rd}, 32'd15);
    check("pri_hold_valid", {31'd0, ex_valid}, 32'd1);
    check("pri_hold_pc4",   ex_pc4, 32'h400);
    ex_stall = 1'b0;
    step();
    flush = 1'b0;
    check("pri_fl_valid", {31'd0, ex_valid}, 32'd0);
    check("pri_fl_ctrl",  {20'd0, ex_ctrl}, 32'd0);
    id_valid = 1'b0;
    step();
    check("idle_bubble", {31'd0, ex_valid}, 32'd0);

    // reset mid-operation clears asynchronously
    drive_id(1'b1, 32'h500, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd17, C_ALU);
    step();
    check("mid_pre_valid", {31'd0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    check("mid_rst_pc4",   ex_pc4, 32'd0);
    check("mid_rst_ctrl",  {20'd0, ex_ctrl}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    check("mid_recap_rd", {27'd0, ex_rd}, 32'd17);

`ifdef ID_EX_PERF_CNT_EN
    // 6: counters
    do_reset();
    drive_id(1'b1, 32'h600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd18, C_ALU);
    check("pc_rst_bub", bubble_cnt, 32'd0);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) step();
    flush    = 1'b0;
    ex_stall = 1'b1;
    for (int i = 0; i < 2; i++) step();
    ex_stall = 1'b0;
    check("pc_bubble", bubble_cnt, 32'd3);
    check("pc_stall",  stall_cnt, 32'd2);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("pc_wrap", bubble_cnt, 32'd0);
`endif

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000 ns");
    $fatal(1);
  end

endmodule : tb_id_ex_pipe_reg
